// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the 16-band serial nonuniform filter bank
// sequencer.
//   - scheduler FSM state encoding
//   - default geometry constants (phases, bands, data widths)
//   - band_slice(): extracts band k from the flattened band result bus
package fb_pkg;

  localparam int unsigned NUM_PHASES = 55;
  localparam int unsigned NUM_BANDS  = 16;
  localparam int unsigned IN_W       = 11;
  localparam int unsigned OUT_W      = 29;
  localparam int unsigned PHASE_W    = 6;
  localparam int unsigned BAND_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_HOLD
  } fb_state_e;

  function automatic logic [OUT_W-1:0] band_slice(
    input logic [NUM_BANDS*OUT_W-1:0] flat,
    input int unsigned                k
  );
    return flat[k*OUT_W +: OUT_W];
  endfunction

endpackage

// File: rtl/fb_out_serializer.sv
// fb_out_serializer: captures all band results in one cycle and streams them
// out over valid/ready, lowest band first, tagged with the band index.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   i_capture      load i_band into the capture registers, restart at band 0
//   i_band         flattened band results, band k at [k*OUT_W +: OUT_W]
//   i_ready        downstream ready
//   o_valid        output valid
//   o_data/o_band  captured result and its band index
//   o_idle         a capture this cycle is allowed (nothing pending after
//                  this cycle's transfer)
module fb_out_serializer #(
  parameter int unsigned NUM_BANDS = 16,
  parameter int unsigned OUT_W     = 29,
  parameter int unsigned BAND_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_capture,
  input  logic [NUM_BANDS*OUT_W-1:0] i_band,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [OUT_W-1:0]           o_data,
  output logic [BAND_W-1:0]          o_band,
  output logic                       o_idle
);

  logic [OUT_W-1:0]  r_cap [NUM_BANDS];
  logic [BAND_W-1:0] r_idx;
  logic              r_valid;
  logic              w_xfer;
  logic              w_last;

  assign w_xfer = r_valid & i_ready;
  assign w_last = (r_idx == BAND_W'(NUM_BANDS - 1));
  // Idle also while the last band is leaving, so a new frame can be captured
  // back-to-back without a gap in o_valid.
  assign o_idle = !r_valid || (w_xfer && w_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      for (int unsigned i = 0; i < NUM_BANDS; i++) r_cap[i] <= '0;
    end else if (i_capture) begin
      r_valid <= 1'b1;
      r_idx   <= '0;
      for (int unsigned i = 0; i < NUM_BANDS; i++) r_cap[i] <= i_band[i*OUT_W +: OUT_W];
    end else if (w_xfer) begin
      if (w_last) r_valid <= 1'b0;
      else        r_idx   <= r_idx + 1'b1;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_cap[r_idx];
  assign o_band  = r_idx;

endmodule

// File: rtl/fb_frame_scheduler.sv
// fb_frame_scheduler: sequencer for the 16-band serial nonuniform filter bank.
// Buffers one input sample, strobes it into the shared delay pipeline, runs
// the shared NUM_PHASES-cycle MAC phase counter and hands each finished frame
// to the output serializer.
// Ports:
//   clock, reset          clock, asynchronous active-high reset
//   clk_enable            advance enable for FSM and phase counter only
//   s_valid/s_ready/s_data   input sample handshake (one-entry buffer)
//   shift_en, sample_out  one-cycle pipeline shift strobe and its sample
//   phase, frame_end      MAC phase broadcast, final-phase flag
//   band_in               flattened band results, band k at [k*OUT_W +: OUT_W]
//   m_valid/m_ready/m_data/m_band   serialized band output stream
//   stall_cnt             enabled cycles spent waiting in HOLD
// Build option: define FB_STALL_CNT_EN to implement stall_cnt (saturating
// 16-bit); otherwise stall_cnt is tied to 0.
module fb_frame_scheduler #(
  parameter int unsigned NUM_PHASES = fb_pkg::NUM_PHASES,
  parameter int unsigned NUM_BANDS  = fb_pkg::NUM_BANDS,
  parameter int unsigned IN_W       = fb_pkg::IN_W,
  parameter int unsigned OUT_W      = fb_pkg::OUT_W,
  parameter int unsigned PHASE_W    = fb_pkg::PHASE_W,
  parameter int unsigned BAND_W     = fb_pkg::BAND_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clk_enable,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [IN_W-1:0]     s_data,
  output logic                       shift_en,
  output logic signed [IN_W-1:0]     sample_out,
  output logic [PHASE_W-1:0]         phase,
  output logic                       frame_end,
  input  logic [NUM_BANDS*OUT_W-1:0] band_in,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic signed [OUT_W-1:0]    m_data,
  output logic [BAND_W-1:0]          m_band,
  output logic [15:0]                stall_cnt
);

  import fb_pkg::*;

  fb_state_e         r_state, w_state_nxt;
  logic [PHASE_W-1:0] r_phase, w_phase_nxt;
  logic              r_buf_full;
  logic [IN_W-1:0]   r_buf;
  logic              w_last_phase;
  logic              w_load;
  logic              w_capture;
  logic              w_ser_idle;

  assign w_last_phase = (r_phase == PHASE_W'(NUM_PHASES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_phase_nxt = '0;
        if (r_buf_full) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_load      = 1'b1;
        w_phase_nxt = '0;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!w_last_phase) begin
          w_phase_nxt = r_phase + 1'b1;
        end else if (w_ser_idle) begin
          w_capture   = 1'b1;
          w_phase_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_ser_idle) begin
          w_capture   = 1'b1;
          w_phase_nxt = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A disabled cycle freezes everything the FSM drives, including the
    // shift strobe and capture, so each still fires exactly once per frame.
    if (!clk_enable) begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_load      = 1'b0;
      w_capture   = 1'b0;
    end
  end

  // One-entry input buffer; handshake runs regardless of clk_enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_buf_full <= 1'b0;
      r_buf      <= '0;
    end else if (w_load) begin
      r_buf_full <= 1'b0;
    end else if (s_valid && !r_buf_full) begin
      r_buf_full <= 1'b1;
      r_buf      <= s_data;
    end
  end

  assign s_ready    = !r_buf_full;
  assign shift_en   = w_load;
  assign sample_out = r_buf;
  assign phase      = r_phase;
  assign frame_end  = (r_state == ST_HOLD) || ((r_state == ST_RUN) && w_last_phase);

  fb_out_serializer #(
    .NUM_BANDS (NUM_BANDS),
    .OUT_W     (OUT_W),
    .BAND_W    (BAND_W)
  ) u_ser (
    .clk       (clock),
    .rst       (reset),
    .i_capture (w_capture),
    .i_band    (band_in),
    .i_ready   (m_ready),
    .o_valid   (m_valid),
    .o_data    (m_data),
    .o_band    (m_band),
    .o_idle    (w_ser_idle)
  );

`ifdef FB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (clk_enable && (r_state == ST_HOLD) && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_frame_scheduler.sv
// Directed testbench for fb_frame_scheduler. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
module tb_fb_frame_scheduler;
  import fb_pkg::*;

  logic                       clock      = 1'b0;
  logic                       reset      = 1'b0;
  logic                       clk_enable = 1'b1;
  logic                       s_valid    = 1'b0;
  logic                       s_ready;
  logic signed [IN_W-1:0]     s_data     = '0;
  logic                       shift_en;
  logic signed [IN_W-1:0]     sample_out;
  logic [PHASE_W-1:0]         phase;
  logic                       frame_end;
  logic [NUM_BANDS*OUT_W-1:0] band_in    = '0;
  logic                       m_valid;
  logic                       m_ready    = 1'b1;
  logic signed [OUT_W-1:0]    m_data;
  logic [BAND_W-1:0]          m_band;
  logic [15:0]                stall_cnt;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clock = ~clock;

  fb_frame_scheduler #(
    .NUM_PHASES (55),
    .NUM_BANDS  (16),
    .IN_W       (11),
    .OUT_W      (29),
    .PHASE_W    (6),
    .BAND_W     (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .clk_enable (clk_enable),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .shift_en   (shift_en),
    .sample_out (sample_out),
    .phase      (phase),
    .frame_end  (frame_end),
    .band_in    (band_in),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_band     (m_band),
    .stall_cnt  (stall_cnt)
  );

  // Distinct value per frame tag and band; odd bands are negative.
  function automatic logic [OUT_W-1:0] band_val(input int unsigned f, input int unsigned k);
    logic [OUT_W-1:0] v;
    v = OUT_W'(f * 100003 + k * 12345 + 7);
    if (k % 2 == 1) v[OUT_W-1] = 1'b1;
    return v;
  endfunction

  task automatic set_bands(input int unsigned f);
    for (int unsigned k = 0; k < NUM_BANDS; k++) band_in[k*OUT_W +: OUT_W] = band_val(f, k);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_sample(input logic signed [IN_W-1:0] d);
    int unsigned n = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && n < 200) begin tick(); n++; end
    n_total++;
    if (s_ready !== 1'b1) $display("FAIL send_timeout: s_ready=%b required 1", s_ready);
    else n_pass++;
    tick();
    s_valid = 1'b0;
  endtask

  // IDLE is the only state where phase stays 0 for several enabled cycles
  // with the buffer empty and nothing streaming.
  task automatic wait_idle();
    int unsigned n = 0, quiet = 0;
    while (quiet < 3 && n < 500) begin
      if (!m_valid && !frame_end && !shift_en && s_ready && phase == '0) quiet++;
      else quiet = 0;
      tick();
      n++;
    end
    n_total++;
    if (quiet < 3) $display("FAIL wait_idle_timeout: quiet=%0d required 3", quiet);
    else n_pass++;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    n_total++; if (shift_en !== 1'b0)   $display("FAIL rst_shift_en: %b required 0", shift_en);     else n_pass++;
    n_total++; if (sample_out !== '0)   $display("FAIL rst_sample_out: %0d required 0", sample_out); else n_pass++;
    n_total++; if (phase !== '0)        $display("FAIL rst_phase: %0d required 0", phase);          else n_pass++;
    n_total++; if (frame_end !== 1'b0)  $display("FAIL rst_frame_end: %b required 0", frame_end);   else n_pass++;
    n_total++; if (m_valid !== 1'b0)    $display("FAIL rst_m_valid: %b required 0", m_valid);       else n_pass++;
    n_total++; if (m_data !== '0)       $display("FAIL rst_m_data: %0d required 0", m_data);        else n_pass++;
    n_total++; if (m_band !== '0)       $display("FAIL rst_m_band: %0d required 0", m_band);        else n_pass++;
    n_total++; if (stall_cnt !== '0)    $display("FAIL rst_stall_cnt: %0d required 0", stall_cnt);  else n_pass++;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_total++; if (s_ready !== 1'b1) $display("FAIL rst_s_ready_after: %b required 1", s_ready); else n_pass++;
    n_total++; if (phase !== '0)     $display("FAIL rst_phase_after: %0d required 0", phase);   else n_pass++;
  endtask

  task automatic test_single();
    int unsigned bad = 0;
    set_bands(1);
    m_ready = 1'b1;
    send_sample(11'sd100);
    // cycle t+1: still IDLE, buffer full
    n_total++; if (shift_en !== 1'b0) $display("FAIL single_no_early_shift: %b required 0", shift_en); else n_pass++;
    n_total++; if (s_ready !== 1'b0)  $display("FAIL single_buf_full: s_ready=%b required 0", s_ready); else n_pass++;
    tick();
    // cycle t+2: LOAD
    n_total++; if (shift_en !== 1'b1)  $display("FAIL single_shift_en: %b required 1", shift_en);        else n_pass++;
    n_total++; if (sample_out !== 11'sd100) $display("FAIL single_sample_out: %0d required 100", sample_out); else n_pass++;
    tick();
    n_total++; if (s_ready !== 1'b1) $display("FAIL single_buf_freed: s_ready=%b required 1", s_ready); else n_pass++;
    for (int unsigned j = 0; j < 55; j++) begin
      if (phase !== PHASE_W'(j) || frame_end !== (j == 54) || m_valid !== 1'b0 || shift_en !== 1'b0) bad++;
      tick();
    end
    n_total++; if (bad != 0) $display("FAIL single_phase_seq: %0d bad cycles required 0", bad); else n_pass++;
    for (int unsigned k = 0; k < NUM_BANDS; k++) begin
      n_total++;
      if ({m_valid, m_band, m_data} !== {1'b1, BAND_W'(k), band_val(1, k)})
        $display("FAIL single_band%0d: v=%b band=%0d data=%h required v=1 band=%0d data=%h",
                 k, m_valid, m_band, m_data, k, band_val(1, k));
      else n_pass++;
      tick();
    end
    n_total++; if (m_valid !== 1'b0) $display("FAIL single_m_valid_drop: %b required 0", m_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic signed [IN_W-1:0] samp [3];
    logic signed [IN_W-1:0] got  [3];
    int unsigned t_pulse [3];
    int unsigned sent = 0, pulses = 0;
    logic hs;
    wait_idle();
    samp[0] = 11'sd5; samp[1] = -11'sd300; samp[2] = 11'sd1023;
    for (int i = 0; i < 3; i++) begin got[i] = '0; t_pulse[i] = 0; end
    set_bands(2);
    m_ready = 1'b1;
    s_data  = samp[0];
    s_valid = 1'b1;
    for (int unsigned c = 0; c < 300 && pulses < 3; c++) begin
      if (shift_en) begin t_pulse[pulses] = c; got[pulses] = sample_out; pulses++; end
      hs = s_valid && s_ready;
      tick();
      if (hs) begin
        sent++;
        if (sent < 3) s_data = samp[sent];
        else s_valid = 1'b0;
      end
    end
    s_valid = 1'b0;
    n_total++; if (pulses != 3) $display("FAIL b2b_pulses: %0d required 3", pulses); else n_pass++;
    n_total++; if (t_pulse[1] - t_pulse[0] != 57) $display("FAIL b2b_gap01: %0d required 57", t_pulse[1] - t_pulse[0]); else n_pass++;
    n_total++; if (t_pulse[2] - t_pulse[1] != 57) $display("FAIL b2b_gap12: %0d required 57", t_pulse[2] - t_pulse[1]); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (got[i] !== samp[i]) $display("FAIL b2b_sample%0d: %0d required %0d", i, got[i], samp[i]);
      else n_pass++;
    end
    n_total++; if (stall_cnt !== '0) $display("FAIL b2b_stall_cnt: %0d required 0", stall_cnt); else n_pass++;
    wait_idle();
  endtask

  task automatic test_backpressure();
    int unsigned n = 0;
    int unsigned bad = 0;
    set_bands(5);
    m_ready = 1'b1;
    send_sample(-11'sd7);
    while (!m_valid && n < 100) begin tick(); n++; end
    n_total++; if (m_valid !== 1'b1) $display("FAIL bp_wait_valid: %b required 1", m_valid); else n_pass++;
    for (int unsigned k = 0; k < 16; k++) begin
      if (k == 7) begin
        m_ready = 1'b0;
        for (int unsigned h = 0; h < 5; h++) begin
          tick();
          if ({m_valid, m_band, m_data} !== {1'b1, BAND_W'(7), band_val(5, 7)}) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL bp_hold_band7: %0d unstable cycles required 0", bad); else n_pass++;
        m_ready = 1'b1;
      end
      n_total++;
      if ({m_valid, m_band, m_data} !== {1'b1, BAND_W'(k), band_val(5, k)})
        $display("FAIL bp_band%0d: v=%b band=%0d data=%h required v=1 band=%0d data=%h",
                 k, m_valid, m_band, m_data, k, band_val(5, k));
      else n_pass++;
      tick();
    end
    n_total++; if (m_valid !== 1'b0) $display("FAIL bp_m_valid_drop: %b required 0", m_valid); else n_pass++;
    wait_idle();
  endtask

  task automatic test_clk_enable();
    int unsigned n = 0, bad = 0;
    set_bands(6);
    m_ready = 1'b1;
    send_sample(11'sd42);
    while (!shift_en && n < 20) begin tick(); n++; end
    n_total++; if (shift_en !== 1'b1) $display("FAIL ce_load: shift_en=%b required 1", shift_en); else n_pass++;
    tick();
    // RUN cycle c: enable high on even c, so phase p spans cycles 2p+1, 2p+2
    for (int unsigned c = 1; c <= 110; c++) begin
      clk_enable = (c % 2 == 0);
      if (c == 5) begin s_valid = 1'b1; s_data = -11'sd512; end
      if (c == 6) s_valid = 1'b0;
      if (phase !== PHASE_W'((c - 1) / 2) || m_valid !== 1'b0 || shift_en !== 1'b0) bad++;
      if (frame_end !== (c >= 109)) bad++;
      if (c >= 6 && s_ready !== 1'b0) bad++;
      tick();
    end
    clk_enable = 1'b1;
    n_total++; if (bad != 0) $display("FAIL ce_run_seq: %0d bad cycles required 0", bad); else n_pass++;
    n_total++; if (m_valid !== 1'b1) $display("FAIL ce_frame_len: m_valid=%b at cycle 111 required 1", m_valid); else n_pass++;
    tick();
    n_total++;
    if ({shift_en, sample_out} !== {1'b1, -11'sd512})
      $display("FAIL ce_next_load: shift_en=%b sample=%0d required 1 and -512", shift_en, sample_out);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_hold();
    int unsigned n = 0, bad = 0, bad2 = 0;
    logic [15:0] exp_stall;
    m_ready = 1'b0;
    set_bands(3);
    send_sample(11'sd11);
    send_sample(-11'sd12);
    while (!frame_end && n < 200) begin tick(); n++; end
    n_total++; if (frame_end !== 1'b1) $display("FAIL hold_wait_frameA: %b required 1", frame_end); else n_pass++;
    tick();
    set_bands(4);
    n = 0;
    while (!frame_end && n < 200) begin tick(); n++; end
    n_total++; if (frame_end !== 1'b1) $display("FAIL hold_wait_frameB: %b required 1", frame_end); else n_pass++;
    // cycle 0 is frame B's last RUN phase; cycles 1..29 wait in HOLD with m_ready low
    for (int unsigned c = 1; c <= 29; c++) begin
      tick();
      if (phase !== PHASE_W'(54) || frame_end !== 1'b1 || m_valid !== 1'b1 || m_band !== '0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL hold_frozen: %0d bad cycles required 0", bad); else n_pass++;
    tick();
    m_ready = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      n_total++;
      if ({m_valid, m_band, m_data} !== {1'b1, BAND_W'(i % 16), band_val(i < 16 ? 3 : 4, i % 16)})
        $display("FAIL hold_stream%0d: v=%b band=%0d data=%h required v=1 band=%0d data=%h",
                 i, m_valid, m_band, m_data, i % 16, band_val(i < 16 ? 3 : 4, i % 16));
      else n_pass++;
      if (frame_end !== (i < 16)) bad2++;
      tick();
    end
    n_total++; if (bad2 != 0) $display("FAIL hold_release: %0d bad frame_end cycles required 0", bad2); else n_pass++;
    n_total++; if (m_valid !== 1'b0) $display("FAIL hold_drain: m_valid=%b required 0", m_valid); else n_pass++;
`ifdef FB_STALL_CNT_EN
    exp_stall = 16'd45;
`else
    exp_stall = 16'd0;
`endif
    n_total++; if (stall_cnt !== exp_stall) $display("FAIL hold_stall_cnt: %0d required %0d", stall_cnt, exp_stall); else n_pass++;
    wait_idle();
  endtask

  task automatic test_reset_midframe();
    int unsigned n = 0, bad = 0;
    set_bands(7);
    m_ready = 1'b1;
    send_sample(11'sd77);
    while (!shift_en && n < 20) begin tick(); n++; end
    tick();
    send_sample(11'sd88);
    n_total++; if (s_ready !== 1'b0) $display("FAIL rmf_buffered: s_ready=%b required 0", s_ready); else n_pass++;
    n = 0;
    while (phase != PHASE_W'(20) && n < 100) begin tick(); n++; end
    n_total++; if (phase !== PHASE_W'(20)) $display("FAIL rmf_reach_phase20: %0d required 20", phase); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++;
    if ({shift_en, sample_out, phase, frame_end, m_valid, m_data, m_band, stall_cnt} !== '0)
      $display("FAIL rmf_async_clear: shift=%b samp=%0d phase=%0d fe=%b mv=%b md=%0d mb=%0d sc=%0d required all 0",
               shift_en, sample_out, phase, frame_end, m_valid, m_data, m_band, stall_cnt);
    else n_pass++;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_total++; if (s_ready !== 1'b1) $display("FAIL rmf_s_ready: %b required 1", s_ready); else n_pass++;
    n_total++; if (phase !== '0)     $display("FAIL rmf_phase: %0d required 0", phase);   else n_pass++;
    for (int unsigned c = 0; c < 10; c++) begin
      if (shift_en !== 1'b0 || phase !== '0 || m_valid !== 1'b0) bad++;
      tick();
    end
    n_total++; if (bad != 0) $display("FAIL rmf_discarded: %0d active cycles required 0", bad); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_clk_enable();
    test_hold();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_total);
    $fatal(1);
  end

endmodule
